cvp14_mem_responder: RTL and testbench

//  Memory-side responder for the CVP14 system bus: serves the processor's word RD/WR requests from an internal word RAM.

---
 rtl/cvp14_mem_pkg.sv | 13 +
 rtl/cvp14_rd_pipe.sv | 33 +++
 rtl/cvp14_mem_responder.sv | 74 +++++++
 tb/tb_cvp14_mem_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cvp14_mem_pkg.sv
// cvp14_mem_pkg: shared constants and types for the CVP14 memory responder
//    FSM state encodings, out-of-range read data, read-latency bound and the read-pipe beat type.
package cvp14_mem_pkg;
   localparam logic [1:0]  ST_IDLE       = 2'b00;
   localparam logic [1:0]  ST_READ       = 2'b01;
   localparam logic [1:0]  ST_WRITE      = 2'b10;
   localparam logic [15:0] BAD_ADDR_DATA = 16'hDEAD;
   localparam int          MAX_READ_LAT  = 4;
   typedef struct packed {
      logic        valid;
      logic [15:0] data;
   } rdBeat_t;
endpackage

// File: rtl/cvp14_rd_pipe.sv
// cvp14_rd_pipe: READ_LAT-deep shift pipeline of {valid, data} read beats
//    Clk1    in   clock
//    Reset_n in   asynchronous active-low clear of every stage
//    inBeat  in   beat entering the pipe
//    outBeat out  beat leaving the pipe READ_LAT edges later; data holds between valid beats
module cvp14_rd_pipe
   import cvp14_mem_pkg::*;
#(
   parameter int READ_LAT = 1
) (
   input  logic    Clk1,
   input  logic    Reset_n,
   input  rdBeat_t inBeat,
   output rdBeat_t outBeat
);
   rdBeat_t prevBeat [READ_LAT];
   rdBeat_t stage    [READ_LAT];
   for (genvar g = 0; g < READ_LAT; g++) begin : gStage
      if (g == 0) begin : gFirst
         assign prevBeat[g] = inBeat;
      end else begin : gNext
         assign prevBeat[g] = stage[g-1];
      end
      // data only moves with a valid beat so the last stage holds the last returned word
      always_ff @(posedge Clk1 or negedge Reset_n)
         if (!Reset_n) stage[g] <= '0;
         else begin
            stage[g].valid <= prevBeat[g].valid;
            if (prevBeat[g].valid) stage[g].data <= prevBeat[g].data;
         end
   end
   assign outBeat = stage[READ_LAT-1];
endmodule

// File: rtl/cvp14_mem_responder.sv
// cvp14_mem_responder: memory-side responder serving CVP14 word RD/WR requests from an internal RAM
//    Clk1/Reset_n       clock, asynchronous active-low reset
//    Addr/RD/WR/WrData  processor bus request
//    RdData/RdValid     read return, READ_LAT edges after RD is sampled
//    Conflict           one-cycle pulse on RD&WR, preload collision or (RANGE_CHK_EN) bad address
//    LdEn/LdAddr/LdData bench preload port, highest priority
//    Macro RANGE_CHK_EN: reject Addr>=DEPTH instead of wrapping modulo DEPTH.
module cvp14_mem_responder
   import cvp14_mem_pkg::*;
#(
   parameter int DEPTH    = 4096,
   parameter int READ_LAT = 1
) (
   input  logic        Clk1,
   input  logic        Reset_n,
   input  logic [15:0] Addr,
   input  logic        RD,
   input  logic        WR,
   input  logic [15:0] WrData,
   output logic [15:0] RdData,
   output logic        RdValid,
   output logic        Conflict,
   input  logic        LdEn,
   input  logic [15:0] LdAddr,
   input  logic [15:0] LdData
);
   localparam int AW = $clog2(DEPTH);
   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] memAddr, ldIdx;
   logic          badAddr, rdEn, wrEn, conflictNext;
   logic [1:0]    state, stateNext;
   logic [3:0]    BurstCnt, burstNext;
   rdBeat_t       inBeat, outBeat;
   logic          unusedBits;
   assign memAddr    = Addr[AW-1:0];
   assign ldIdx      = LdAddr[AW-1:0];
   assign unusedBits = ^{Addr[15:AW], LdAddr[15:AW]};
`ifdef RANGE_CHK_EN
   assign badAddr = 32'(Addr) >= 32'(DEPTH);
`else
   assign badAddr = 1'b0;
`endif
   // preload wins over the bus; RD&WR together cancels both
   assign rdEn         = RD & ~WR & ~LdEn;
   assign wrEn         = WR & ~RD & ~LdEn & ~badAddr;
   assign conflictNext = (LdEn & (RD | WR)) | (RD & WR) | (~LdEn & (RD ^ WR) & badAddr);
   assign inBeat       = '{valid: rdEn, data: badAddr ? BAD_ADDR_DATA : mem[memAddr]};
   always_ff @(posedge Clk1)
      if (LdEn) mem[ldIdx] <= LdData;
      else if (wrEn) mem[memAddr] <= WrData;
   cvp14_rd_pipe #(.READ_LAT(READ_LAT)) uPipe (
      .Clk1    (Clk1),
      .Reset_n (Reset_n),
      .inBeat  (inBeat),
      .outBeat (outBeat)
   );
   assign RdData  = outBeat.data;
   assign RdValid = outBeat.valid;
   // the FSM follows raw bus activity; preload does not influence it
   always_comb begin
      stateNext = (RD & ~WR) ? ST_READ : (WR & ~RD) ? ST_WRITE : ST_IDLE;
      burstNext = (RD & ~WR) ? ((state == ST_READ) ? BurstCnt + 4'd1 : 4'd0) : BurstCnt;
   end
   always_ff @(posedge Clk1 or negedge Reset_n)
      if (!Reset_n) begin
         state    <= ST_IDLE;
         BurstCnt <= '0;
         Conflict <= 1'b0;
      end else begin
         state    <= stateNext;
         BurstCnt <= burstNext;
         Conflict <= conflictNext;
      end
endmodule

// File: tb/tb_cvp14_mem_responder.sv
// tb_cvp14_mem_responder: directed self-checking bench for cvp14_mem_responder (READ_LAT 2 and 4 instances)
module tb_cvp14_mem_responder;
   logic        Clk1 = 1'b0;
   logic        resetA_n = 1'b0, resetB_n = 1'b0;
   logic [15:0] Addr = '0, WrData = '0, LdAddr = '0, LdData = '0;
   logic        RD = 1'b0, WR = 1'b0, LdEn = 1'b0;
   logic [15:0] rdDataA, rdDataB;
   logic        rdValidA, rdValidB, conflictA, conflictB;
   int          nChecks = 0, nFails = 0;

   always #5 Clk1 = ~Clk1;

   cvp14_mem_responder #(.DEPTH(4096), .READ_LAT(2)) dutA (
      .Clk1(Clk1), .Reset_n(resetA_n), .Addr(Addr), .RD(RD), .WR(WR), .WrData(WrData),
      .RdData(rdDataA), .RdValid(rdValidA), .Conflict(conflictA),
      .LdEn(LdEn), .LdAddr(LdAddr), .LdData(LdData));

   cvp14_mem_responder #(.DEPTH(4096), .READ_LAT(4)) dutB (
      .Clk1(Clk1), .Reset_n(resetB_n), .Addr(Addr), .RD(RD), .WR(WR), .WrData(WrData),
      .RdData(rdDataB), .RdValid(rdValidB), .Conflict(conflictB),
      .LdEn(LdEn), .LdAddr(LdAddr), .LdData(LdData));

   task automatic tick();
      @(posedge Clk1);
      #1;
   endtask

   task automatic preload(input logic [15:0] a, input logic [15:0] d);
      LdEn = 1'b1; LdAddr = a; LdData = d;
      tick();
      LdEn = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      nChecks++; if (rdDataA !== 16'h0) begin nFails++; $display("FAIL reset_rddata_a got %h exp 0000", rdDataA); end
      nChecks++; if (rdValidA !== 1'b0) begin nFails++; $display("FAIL reset_rdvalid_a got %b exp 0", rdValidA); end
      nChecks++; if (conflictA !== 1'b0) begin nFails++; $display("FAIL reset_conflict_a got %b exp 0", conflictA); end
      nChecks++; if (rdDataB !== 16'h0) begin nFails++; $display("FAIL reset_rddata_b got %h exp 0000", rdDataB); end
      nChecks++; if (rdValidB !== 1'b0) begin nFails++; $display("FAIL reset_rdvalid_b got %b exp 0", rdValidB); end
      nChecks++; if (dutA.BurstCnt !== 4'd0) begin nFails++; $display("FAIL reset_burstcnt_a got %0d exp 0", dutA.BurstCnt); end
      tick();
      resetA_n = 1'b1; resetB_n = 1'b1;
      tick(); tick();
   endtask

   task automatic test_single_read();
      preload(16'h0010, 16'h1234);
      Addr = 16'h0010; RD = 1'b1;
      tick();
      RD = 1'b0;
      nChecks++; if (rdValidA !== 1'b0) begin nFails++; $display("FAIL single_early_valid got %b exp 0", rdValidA); end
      tick();
      nChecks++; if (rdValidA !== 1'b1) begin nFails++; $display("FAIL single_valid got %b exp 1", rdValidA); end
      nChecks++; if (rdDataA !== 16'h1234) begin nFails++; $display("FAIL single_data got %h exp 1234", rdDataA); end
      tick();
      nChecks++; if (rdValidA !== 1'b0) begin nFails++; $display("FAIL single_late_valid got %b exp 0", rdValidA); end
      nChecks++; if (rdDataA !== 16'h1234) begin nFails++; $display("FAIL single_hold_data got %h exp 1234", rdDataA); end
   endtask

   task automatic test_burst();
      for (int i = 0; i < 16; i++) preload(16'h0100 + 16'(i), 16'hA000 + 16'(i));
      for (int k = 0; k < 18; k++) begin
         RD = (k < 16); Addr = 16'h0100 + 16'(k);
         tick();
         nChecks++;
         if (rdValidA !== (k >= 1 && k <= 16)) begin
            nFails++; $display("FAIL burst_valid[%0d] got %b exp %b", k, rdValidA, (k >= 1 && k <= 16));
         end
         if (k >= 1 && k <= 16) begin
            nChecks++;
            if (rdDataA !== 16'hA000 + 16'(k - 1)) begin
               nFails++; $display("FAIL burst_data[%0d] got %h exp %h", k, rdDataA, 16'hA000 + 16'(k - 1));
            end
         end
         if (k == 15) begin
            nChecks++; if (dutA.BurstCnt !== 4'd15) begin nFails++; $display("FAIL burst_cnt got %0d exp 15", dutA.BurstCnt); end
            nChecks++; if (dutA.state !== 2'b01) begin nFails++; $display("FAIL burst_state got %b exp 01", dutA.state); end
         end
      end
      nChecks++; if (dutA.state !== 2'b00) begin nFails++; $display("FAIL burst_idle got %b exp 00", dutA.state); end
   endtask

   task automatic test_write_read();
      WR = 1'b1; Addr = 16'h0020; WrData = 16'hBEEF;
      tick();
      nChecks++; if (dutA.state !== 2'b10) begin nFails++; $display("FAIL wr_state got %b exp 10", dutA.state); end
      WR = 1'b0; RD = 1'b1;
      tick();
      RD = 1'b0;
      nChecks++; if (dutA.BurstCnt !== 4'd0) begin nFails++; $display("FAIL wr_rd_burstcnt got %0d exp 0", dutA.BurstCnt); end
      nChecks++; if (rdValidA !== 1'b0) begin nFails++; $display("FAIL wr_rd_early got %b exp 0", rdValidA); end
      tick();
      nChecks++; if (rdValidA !== 1'b1) begin nFails++; $display("FAIL wr_rd_valid got %b exp 1", rdValidA); end
      nChecks++; if (rdDataA !== 16'hBEEF) begin nFails++; $display("FAIL wr_rd_data got %h exp beef", rdDataA); end
      tick();
   endtask

   task automatic test_conflict();
      preload(16'h0030, 16'h5555);
      preload(16'h0041, 16'h2222);
      RD = 1'b1; WR = 1'b1; Addr = 16'h0030; WrData = 16'hFFFF;
      tick();
      RD = 1'b0; WR = 1'b0;
      nChecks++; if (conflictA !== 1'b1) begin nFails++; $display("FAIL rdwr_conflict got %b exp 1", conflictA); end
      nChecks++; if (dutA.state !== 2'b00) begin nFails++; $display("FAIL rdwr_state got %b exp 00", dutA.state); end
      tick();
      nChecks++; if (conflictA !== 1'b0) begin nFails++; $display("FAIL rdwr_conflict_pulse got %b exp 0", conflictA); end
      nChecks++; if (rdValidA !== 1'b0) begin nFails++; $display("FAIL rdwr_no_valid got %b exp 0", rdValidA); end
      RD = 1'b1;
      tick();
      RD = 1'b0;
      tick();
      nChecks++; if (rdDataA !== 16'h5555) begin nFails++; $display("FAIL rdwr_mem got %h exp 5555", rdDataA); end
      LdEn = 1'b1; LdAddr = 16'h0040; LdData = 16'h7777;
      WR = 1'b1; Addr = 16'h0041; WrData = 16'h1111;
      tick();
      LdEn = 1'b0; WR = 1'b0;
      nChecks++; if (conflictA !== 1'b1) begin nFails++; $display("FAIL ld_conflict got %b exp 1", conflictA); end
      RD = 1'b1; Addr = 16'h0040;
      tick();
      Addr = 16'h0041;
      nChecks++; if (conflictA !== 1'b0) begin nFails++; $display("FAIL ld_conflict_pulse got %b exp 0", conflictA); end
      tick();
      RD = 1'b0;
      nChecks++; if (rdDataA !== 16'h7777) begin nFails++; $display("FAIL ld_data got %h exp 7777", rdDataA); end
      tick();
      nChecks++; if (rdDataA !== 16'h2222) begin nFails++; $display("FAIL ld_dropped_wr got %h exp 2222", rdDataA); end
      tick();
   endtask

   task automatic test_range();
      preload(16'h0000, 16'h0F0F);
      RD = 1'b1; Addr = 16'h1000;
      tick();
      RD = 1'b0;
`ifdef RANGE_CHK_EN
      nChecks++; if (conflictA !== 1'b1) begin nFails++; $display("FAIL range_rd_conflict got %b exp 1", conflictA); end
      tick();
      nChecks++; if (rdValidA !== 1'b1) begin nFails++; $display("FAIL range_rd_valid got %b exp 1", rdValidA); end
      nChecks++; if (rdDataA !== 16'hDEAD) begin nFails++; $display("FAIL range_rd_data got %h exp dead", rdDataA); end
`else
      nChecks++; if (conflictA !== 1'b0) begin nFails++; $display("FAIL wrap_rd_conflict got %b exp 0", conflictA); end
      tick();
      nChecks++; if (rdValidA !== 1'b1) begin nFails++; $display("FAIL wrap_rd_valid got %b exp 1", rdValidA); end
      nChecks++; if (rdDataA !== 16'h0F0F) begin nFails++; $display("FAIL wrap_rd_data got %h exp 0f0f", rdDataA); end
`endif
      WR = 1'b1; WrData = 16'hAAAA;
      tick();
      WR = 1'b0;
`ifdef RANGE_CHK_EN
      nChecks++; if (conflictA !== 1'b1) begin nFails++; $display("FAIL range_wr_conflict got %b exp 1", conflictA); end
`else
      nChecks++; if (conflictA !== 1'b0) begin nFails++; $display("FAIL wrap_wr_conflict got %b exp 0", conflictA); end
`endif
      RD = 1'b1; Addr = 16'h0000;
      tick();
      RD = 1'b0;
      tick();
`ifdef RANGE_CHK_EN
      nChecks++; if (rdDataA !== 16'h0F0F) begin nFails++; $display("FAIL range_wr_dropped got %h exp 0f0f", rdDataA); end
`else
      nChecks++; if (rdDataA !== 16'hAAAA) begin nFails++; $display("FAIL wrap_wr_data got %h exp aaaa", rdDataA); end
`endif
      tick(); tick(); tick();
   endtask

   task automatic test_reset_flush();
      nChecks++; if (rdDataB === 16'h0) begin nFails++; $display("FAIL flush_pre_data got %h exp nonzero", rdDataB); end
      RD = 1'b1;
      for (int i = 0; i < 3; i++) begin
         Addr = 16'h0010 + 16'(i);
         tick();
      end
      RD = 1'b0;
      nChecks++; if (rdValidB !== 1'b0) begin nFails++; $display("FAIL flush_pre_valid got %b exp 0", rdValidB); end
      resetB_n = 1'b0;
      #1;
      nChecks++; if (rdDataB !== 16'h0) begin nFails++; $display("FAIL flush_rddata got %h exp 0000", rdDataB); end
      nChecks++; if (rdValidB !== 1'b0) begin nFails++; $display("FAIL flush_rdvalid got %b exp 0", rdValidB); end
      nChecks++; if (dutB.BurstCnt !== 4'd0) begin nFails++; $display("FAIL flush_burstcnt got %0d exp 0", dutB.BurstCnt); end
      tick();
      resetB_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         nChecks++; if (rdValidB !== 1'b0) begin nFails++; $display("FAIL flush_post_valid[%0d] got %b exp 0", i, rdValidB); end
      end
      RD = 1'b1; Addr = 16'h0010;
      tick();
      RD = 1'b0;
      tick(); tick();
      nChecks++; if (rdValidB !== 1'b0) begin nFails++; $display("FAIL lat4_early got %b exp 0", rdValidB); end
      tick();
      nChecks++; if (rdValidB !== 1'b1) begin nFails++; $display("FAIL lat4_valid got %b exp 1", rdValidB); end
      nChecks++; if (rdDataB !== 16'h1234) begin nFails++; $display("FAIL lat4_data got %h exp 1234", rdDataB); end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_burst();
      test_write_read();
      test_conflict();
      test_range();
      test_reset_flush();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule
